// File: rtl/laser_cover_eval.sv
// laser_cover_eval: loads NPTS 4-bit points (PT_*), evaluates two-circle candidates (CAND_*), reports covered count (RES_*) and tracks the best pair (BEST_*)
module laser_cover_eval #(
  parameter int NPTS = 40,
  parameter int R2   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       PT_VLD,
  input  logic [3:0] PT_X,
  input  logic [3:0] PT_Y,
  output logic       LOADED,
  input  logic       CAND_VLD,
  output logic       CAND_RDY,
  input  logic [3:0] CAND_C1X,
  input  logic [3:0] CAND_C1Y,
  input  logic [3:0] CAND_C2X,
  input  logic [3:0] CAND_C2Y,
  output logic       RES_VLD,
  output logic [5:0] RES_CNT,
  output logic       RES_BEST,
  output logic [3:0] BEST_C1X,
  output logic [3:0] BEST_C1Y,
  output logic [3:0] BEST_C2X,
  output logic [3:0] BEST_C2Y,
  output logic [5:0] BEST_CNT
);
  localparam int IW = $clog2(NPTS + 1);
  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_EVAL, S_RESULT} state_t;
  state_t r_state;
  logic [7:0] r_mem [NPTS];
  logic [IW-1:0] r_widx, r_eidx;
  logic [3:0] r_px, r_py, r_c1x, r_c1y, r_c2x, r_c2y;
  logic r_pv, r_loaded, r_rdy, r_res_vld, r_res_best;
  logic [5:0] r_cnt, r_res_cnt, r_best_cnt;
  logic [15:0] r_best_c;
  logic w_wr, w_cov;
  logic [5:0] w_cnt_nxt;
  function automatic logic [8:0] f_d2(input logic [3:0] px, py, cx, cy);
    logic [3:0] dx, dy;
    dx = px >= cx ? px - cx : cx - px;
    dy = py >= cy ? py - cy : cy - py;
    return 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
  endfunction
  assign w_wr = r_state == S_LOAD && PT_VLD && !CLR;
  assign w_cov = f_d2(r_px, r_py, r_c1x, r_c1y) <= 9'(R2) || f_d2(r_px, r_py, r_c2x, r_c2y) <= 9'(R2);
  assign w_cnt_nxt = r_cnt + 6'(r_pv & w_cov);
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_widx] <= {PT_X, PT_Y};
  end
  // EVAL reads one point per cycle into r_px/r_py and scores it a cycle later,
  // so the last point is scored on the edge that enters RESULT (T+NPTS+1).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_LOAD;
      r_widx     <= '0;
      r_eidx     <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_pv       <= 1'b0;
      r_c1x      <= '0;
      r_c1y      <= '0;
      r_c2x      <= '0;
      r_c2y      <= '0;
      r_cnt      <= '0;
      r_loaded   <= 1'b0;
      r_rdy      <= 1'b0;
      r_res_vld  <= 1'b0;
      r_res_best <= 1'b0;
      r_res_cnt  <= '0;
      r_best_cnt <= '0;
      r_best_c   <= '0;
    end else if (CLR) begin
      r_state    <= S_LOAD;
      r_widx     <= '0;
      r_eidx     <= '0;
      r_pv       <= 1'b0;
      r_loaded   <= 1'b0;
      r_rdy      <= 1'b0;
      r_res_vld  <= 1'b0;
      r_res_best <= 1'b0;
      r_res_cnt  <= '0;
      r_best_cnt <= '0;
      r_best_c   <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (PT_VLD) begin
          r_widx <= r_widx == IW'(NPTS - 1) ? '0 : r_widx + 1'b1;
          if (r_widx == IW'(NPTS - 1)) begin
            r_state  <= S_WAIT;
            r_loaded <= 1'b1;
            r_rdy    <= 1'b1;
          end
        end
        S_WAIT: if (CAND_VLD) begin
          r_c1x   <= CAND_C1X;
          r_c1y   <= CAND_C1Y;
          r_c2x   <= CAND_C2X;
          r_c2y   <= CAND_C2Y;
          r_cnt   <= '0;
          r_eidx  <= '0;
          r_pv    <= 1'b0;
          r_rdy   <= 1'b0;
          r_state <= S_EVAL;
        end
        S_EVAL: if (r_eidx == IW'(NPTS)) begin
          r_pv       <= 1'b0;
          r_cnt      <= w_cnt_nxt;
          r_res_vld  <= 1'b1;
          r_res_cnt  <= w_cnt_nxt;
          r_res_best <= w_cnt_nxt > r_best_cnt;
          if (w_cnt_nxt > r_best_cnt) begin
            r_best_cnt <= w_cnt_nxt;
            r_best_c   <= {r_c1x, r_c1y, r_c2x, r_c2y};
          end
          r_state <= S_RESULT;
        end else begin
          {r_px, r_py} <= r_mem[r_eidx];
          r_pv   <= 1'b1;
          r_cnt  <= w_cnt_nxt;
          r_eidx <= r_eidx + 1'b1;
        end
        S_RESULT: begin
          r_res_vld  <= 1'b0;
          r_res_best <= 1'b0;
          r_rdy      <= 1'b1;
          r_state    <= S_WAIT;
        end
      endcase
    end
  end
  assign LOADED = r_loaded;
  assign CAND_RDY = r_rdy;
  assign RES_VLD = r_res_vld;
  assign RES_CNT = r_res_cnt;
  assign RES_BEST = r_res_best;
  assign BEST_CNT = r_best_cnt;
  assign {BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y} = r_best_c;
endmodule

// File: tb/tb_laser_cover_eval.sv
// tb_laser_cover_eval: directed vector table plus reset/clear/handshake corner sequences
module tb_laser_cover_eval;
  logic CLK = 1'b0, RST = 1'b1, CLR = 1'b0, PT_VLD = 1'b0, CAND_VLD = 1'b0;
  logic [3:0] PT_X = '0, PT_Y = '0, CAND_C1X = '0, CAND_C1Y = '0, CAND_C2X = '0, CAND_C2Y = '0;
  logic LOADED, CAND_RDY, RES_VLD, RES_BEST;
  logic [5:0] RES_CNT, BEST_CNT;
  logic [3:0] BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y;
  int n_cmp = 0, n_err = 0;
  laser_cover_eval dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .PT_VLD(PT_VLD), .PT_X(PT_X), .PT_Y(PT_Y),
    .LOADED(LOADED), .CAND_VLD(CAND_VLD), .CAND_RDY(CAND_RDY),
    .CAND_C1X(CAND_C1X), .CAND_C1Y(CAND_C1Y), .CAND_C2X(CAND_C2X), .CAND_C2Y(CAND_C2Y),
    .RES_VLD(RES_VLD), .RES_CNT(RES_CNT), .RES_BEST(RES_BEST),
    .BEST_C1X(BEST_C1X), .BEST_C1Y(BEST_C1Y), .BEST_C2X(BEST_C2X), .BEST_C2Y(BEST_C2Y),
    .BEST_CNT(BEST_CNT)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    bit ld;
    logic [3:0] ax, ay;
    int na;
    logic [3:0] bx, by;
    logic [15:0] cand;
    logic [5:0] cnt;
    logic best;
    logic [5:0] bcnt;
    logic [15:0] bc;
  } vec_t;
  vec_t tv [9];
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] all_out();
    return {LOADED, CAND_RDY, RES_VLD, RES_BEST, RES_CNT, BEST_CNT, BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y};
  endfunction
  task automatic do_load(input string nm, input logic [3:0] ax, ay, input int na, input logic [3:0] bx, by);
    for (int i = 0; i < 40; i++) begin
      PT_VLD = 1'b1;
      {PT_X, PT_Y} = i < na ? {ax, ay} : {bx, by};
      tick;
    end
    PT_VLD = 1'b0;
    chk({nm, " loaded"}, 32'(LOADED), 32'd1);
  endtask
  task automatic run_cand(input string nm, input logic [15:0] c, input logic [5:0] ecnt,
                          input logic eb, input logic [5:0] ebcnt, input logic [15:0] ebc);
    int lat;
    lat = 0;
    {CAND_C1X, CAND_C1Y, CAND_C2X, CAND_C2Y} = c;
    CAND_VLD = 1'b1;
    chk({nm, " rdy_wait"}, 32'(CAND_RDY), 32'd1);
    tick;
    CAND_VLD = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (RES_VLD) begin
        lat = k;
        break;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'd41);
    chk({nm, " res_cnt"}, 32'(RES_CNT), 32'(ecnt));
    chk({nm, " res_best"}, 32'(RES_BEST), 32'(eb));
    chk({nm, " best_cnt"}, 32'(BEST_CNT), 32'(ebcnt));
    chk({nm, " best_c"}, 32'({BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y}), 32'(ebc));
    chk({nm, " rdy_result"}, 32'(CAND_RDY), 32'd0);
    tick;
    chk({nm, " after"}, 32'({RES_VLD, RES_BEST, CAND_RDY, RES_CNT}), 32'({3'b001, ecnt}));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad;
    tv[0] = '{1'b1, 4'd0, 4'd0, 40, 4'd0, 4'd0, 16'h00FF, 6'd40, 1'b1, 6'd40, 16'h00FF};
    tv[1] = '{1'b0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 16'hFF00, 6'd40, 1'b0, 6'd40, 16'h00FF};
    tv[2] = '{1'b1, 4'd4, 4'd0, 20, 4'd3, 4'd3, 16'h00FF, 6'd20, 1'b1, 6'd20, 16'h00FF};
    tv[3] = '{1'b0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 16'h33FF, 6'd40, 1'b1, 6'd40, 16'h33FF};
    tv[4] = '{1'b0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 16'hF00F, 6'd0, 1'b0, 6'd40, 16'h33FF};
    tv[5] = '{1'b1, 4'd7, 4'd7, 10, 4'd12, 4'd12, 16'h00C8, 6'd30, 1'b1, 6'd30, 16'h00C8};
    tv[6] = '{1'b0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 16'h77CC, 6'd40, 1'b1, 6'd40, 16'h77CC};
    tv[7] = '{1'b0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 16'hCC77, 6'd40, 1'b0, 6'd40, 16'h77CC};
    tv[8] = '{1'b1, 4'd0, 4'd0, 20, 4'd15, 4'd15, 16'hEEEE, 6'd20, 1'b1, 6'd20, 16'hEEEE};
    #2;
    chk("reset outputs", all_out(), 32'd0);
    tick;
    RST = 1'b0;
    tick;
    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      if (tv[v].ld) begin
        CLR = 1'b1;
        tick;
        CLR = 1'b0;
        do_load(nm, tv[v].ax, tv[v].ay, tv[v].na, tv[v].bx, tv[v].by);
      end else begin
        PT_VLD = 1'b1;
        PT_X = 4'd15;
        PT_Y = 4'd0;
        repeat (3) tick;
        PT_VLD = 1'b0;
      end
      run_cand(nm, tv[v].cand, tv[v].cnt, tv[v].best, tv[v].bcnt, tv[v].bc);
    end
    CAND_VLD = 1'b1;
    {CAND_C1X, CAND_C1Y, CAND_C2X, CAND_C2Y} = 16'h8888;
    CLR = 1'b1;
    tick;
    CLR = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (CAND_RDY && !LOADED) bad++;
      PT_VLD = 1'b1;
      PT_X = 4'd8;
      PT_Y = 4'd8;
      tick;
    end
    PT_VLD = 1'b0;
    chk("hold rdy_before_loaded", 32'(bad), 32'd0);
    chk("hold loaded", 32'({LOADED, CAND_RDY}), 32'd3);
    run_cand("hold", 16'h8888, 6'd40, 1'b1, 6'd40, 16'h8888);
    {CAND_C1X, CAND_C1Y, CAND_C2X, CAND_C2Y} = 16'h00FF;
    CAND_VLD = 1'b1;
    tick;
    CAND_VLD = 1'b0;
    repeat (10) tick;
    RST = 1'b1;
    #1;
    chk("rst_eval outputs", all_out(), 32'd0);
    tick;
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (RES_VLD) bad++;
    end
    chk("rst_eval no_res_vld", 32'(bad), 32'd0);
    do_load("rst_reload", 4'd1, 4'd1, 20, 4'd9, 4'd9);
    run_cand("rst_reload", 16'h00FF, 6'd20, 1'b1, 6'd20, 16'h00FF);
    {CAND_C1X, CAND_C1Y, CAND_C2X, CAND_C2Y} = 16'h99FF;
    CAND_VLD = 1'b1;
    CLR = 1'b1;
    tick;
    CLR = 1'b0;
    chk("clr_hs state", 32'({LOADED, CAND_RDY, BEST_CNT, RES_CNT, BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y}), 32'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (RES_VLD || CAND_RDY) bad++;
    end
    CAND_VLD = 1'b0;
    chk("clr_hs not_accepted", 32'(bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/laser_cover_eval.md
LASER_COVER_EVAL -- requirements
Module: laser_cover_eval

Interface
REQ-001 The block SHALL have parameter NPTS, default 40, number of target points per frame.
REQ-002 The block SHALL have parameter R2, default 16, squared laser radius; the coverage test is inclusive.
REQ-003 The block SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port CLR  in  1  synchronous frame clear.
REQ-006 The block SHALL have ports PT_VLD  in  1, PT_X  in  4, PT_Y  in  4  for point load strobe and coordinates.
REQ-007 The block SHALL have port LOADED  out  1  high when all NPTS points are stored.
REQ-008 The block SHALL have ports CAND_VLD  in  1 and CAND_RDY  out  1  for the candidate handshake.
REQ-009 The block SHALL have ports CAND_C1X, CAND_C1Y, CAND_C2X, CAND_C2Y, each  in  4, holding the candidate circle centres.
REQ-010 The block SHALL have ports RES_VLD  out  1, RES_CNT  out  6, RES_BEST  out  1, which carry the result strobe, the covered count and the new-best flag.
REQ-011 The block SHALL have ports BEST_C1X, BEST_C1Y, BEST_C2X, BEST_C2Y, each  out  4, and BEST_CNT  out  6, which hold the best pair so far.

Function
REQ-012 The block SHALL use states LOAD, WAIT, EVAL and RESULT, with LOAD as the reset state.
REQ-013 In LOAD, each cycle with PT_VLD=1 SHALL store (PT_X,PT_Y) at write index 0..NPTS-1, then increment the index; PT_VLD=0 cycles SHALL hold the index.
REQ-014 Storing point NPTS-1 SHALL move the state to WAIT and set LOADED=1 in the next cycle; PT_VLD SHALL be ignored outside LOAD.
REQ-015 CAND_RDY SHALL be 1 only in WAIT; a candidate is accepted on any edge with CAND_VLD=1 and CAND_RDY=1 in the same cycle, and the block SHALL latch all four centre coordinates and enter EVAL.
REQ-016 EVAL SHALL test one stored point per cycle, indices 0..NPTS-1, for exactly NPTS cycles.
REQ-017 Per point, the block SHALL compute dx=|px-cx| and dy=|py-cy| as 4-bit unsigned values with no wrap, and d2=dx*dx+dy*dy at 9 bits.
REQ-018 A point SHALL be covered when d2<=R2 for C1 or for C2; a point inside both circles SHALL be counted once, and duplicate points SHALL each be counted.
REQ-019 The covered count SHALL accumulate in a 6-bit counter that is cleared on acceptance; its range is 0..40.
REQ-020 After the last point the block SHALL enter RESULT, where RES_VLD=1 for exactly one cycle and RES_CNT holds the final count.
REQ-021 Latency SHALL be fixed: with acceptance on edge T, RES_VLD SHALL be high in cycle T+NPTS+1 (T+41 by default); the block SHALL return to WAIT with CAND_RDY=1 in the following cycle.
REQ-022 In RESULT, if RES_CNT>BEST_CNT (strictly), the block SHALL set RES_BEST=1 and update BEST_CNT and BEST_C* from the latched candidate; on a tie or a lower count, RES_BEST=0 and the best registers SHALL hold.
REQ-023 RES_CNT SHALL hold its value until the next RESULT; RES_BEST SHALL be 0 outside RESULT.
REQ-024 CLR=1 SHALL, in any state, return the block to LOAD at the next edge with write index 0 and LOADED=0, clear BEST_* and RES_*, and drop any in-flight evaluation.
REQ-025 CLR SHALL take priority over a simultaneous CAND_VLD handshake and over PT_VLD.
REQ-026 Stored points SHALL survive CLR; they are overwritten only by a new load.

Reset
REQ-027 RST=1 SHALL immediately force the state to LOAD and the write and eval indices to 0.
REQ-028 RST=1 SHALL immediately force LOADED=0, CAND_RDY=0, RES_VLD=0, RES_BEST=0, RES_CNT=0, BEST_CNT=0 and all BEST_C*=0, independent of CLK.
REQ-029 Point storage SHALL need no reset.
REQ-030 Reset asserted mid-EVAL SHALL abandon the evaluation and produce no RES_VLD pulse.

Verification
REQ-031 Bench SHALL load 40 points at (0,0) and submit C1=(0,0), C2=(15,15) -> RES_VLD at T+41 with RES_CNT=40, RES_BEST=1, BEST=(0,0,15,15), BEST_CNT=40.
REQ-032 Bench SHALL load 20 points at (4,0) and 20 at (3,3) and submit C1=(0,0), C2=(15,15) -> RES_CNT=20 (d2=16 covered, d2=18 not).
REQ-033 Bench SHALL submit a second candidate, C1=(15,15), C2=(0,0), after REQ-031 -> RES_CNT=40, RES_BEST=0, BEST unchanged.
REQ-034 Bench SHALL load 40 points at (8,8), hold CAND_VLD=1 with C1=C2=(8,8) throughout the load -> CAND_RDY=0 until LOADED=1; RES_CNT=40 with the point counted once despite overlapping circles.
REQ-035 Bench SHALL assert RST at EVAL cycle 10 -> all outputs 0 and no RES_VLD; after reload and a new candidate, the result is correct.
REQ-036 Bench SHALL assert CLR in the same cycle as a CAND_VLD handshake in WAIT -> candidate not accepted, state LOAD, LOADED=0, BEST_CNT=0.
